// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences IR/MDR/A/B/ALUOut datapath with a shared ALU and
// unified memory, waits on mem_ready with a bounded timeout, and halts on illegal opcodes.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       ge,
  input  logic       ovf,
  input  logic       mem_ready,
  output logic       PCWr,
  output logic       IRWr,
  output logic       memRead,
  output logic       memWrite,
  output logic       IorD,
  output logic       regWrite,
  output logic [1:0] regDst,
  output logic [1:0] writeData,
  output logic [2:0] nPCsel,
  output logic [1:0] extsel,
  output logic [1:0] ALUsel,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       slt_ctrl,
  output logic       halted,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEM_ADR = 4'd2;
  localparam logic [3:0] MEM_RD  = 4'd3;
  localparam logic [3:0] MEM_WB  = 4'd4;
  localparam logic [3:0] MEM_WR  = 4'd5;
  localparam logic [3:0] EXE_R   = 4'd6;
  localparam logic [3:0] R_WB    = 4'd7;
  localparam logic [3:0] EXE_I   = 4'd8;
  localparam logic [3:0] I_WB    = 4'd9;
  localparam logic [3:0] BRANCH  = 4'd10;
  localparam logic [3:0] JUMP    = 4'd11;
  localparam logic [3:0] JAL     = 4'd12;
  localparam logic [3:0] JR      = 4'd13;
  localparam logic [3:0] HALT    = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BGE   = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_SLT  = 6'b101010;

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WaitMax = CW'(TIMEOUT - 1);

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          ovf_q, ovf_d;
  logic          timed_out, is_slt, mem_state;

  assign timed_out = (wait_q == WaitMax);
  assign is_slt    = (opcode == OP_RTYPE) && (funct == F_SLT);
  assign mem_state = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
  assign state     = state_q;

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    case (state_q)
      FETCH:   if (mem_ready) state_d = DECODE; else if (timed_out) state_d = HALT;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:           state_d = MEM_ADR;
          OP_ORI, OP_LUI, OP_ADDI: state_d = EXE_I;
          OP_BEQ, OP_BGE:         state_d = BRANCH;
          OP_J:                   state_d = JUMP;
          OP_JAL:                 state_d = JAL;
          OP_RTYPE: begin
            case (funct)
              F_ADDU, F_SUBU, F_SLT: state_d = EXE_R;
              F_JR:                  state_d = JR;
              default:               state_d = HALT;
            endcase
          end
          default:                state_d = HALT;
        endcase
      end
      MEM_ADR: state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:  if (mem_ready) state_d = MEM_WB; else if (timed_out) state_d = HALT;
      MEM_WR:  if (mem_ready) state_d = FETCH; else if (timed_out) state_d = HALT;
      EXE_R:   state_d = R_WB;
      EXE_I: begin
        ovf_d   = (opcode == OP_ADDI) && ovf;
        state_d = I_WB;
      end
      MEM_WB, R_WB, I_WB, BRANCH, JUMP, JAL, JR: state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  always_comb begin
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_state && !mem_ready) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = wait_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      wait_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs are forced low while reset is held so an aborted access drops its strobe at once.
  always_comb begin
    PCWr      = 1'b0;
    IRWr      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    IorD      = 1'b0;
    regWrite  = 1'b0;
    regDst    = 2'b00;
    writeData = 2'b00;
    nPCsel    = 3'b000;
    extsel    = 2'b00;
    ALUsel    = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    slt_ctrl  = 1'b0;
    halted    = 1'b0;
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          memRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWr    = mem_ready;
          PCWr    = mem_ready;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          extsel  = 2'b01;
        end
        MEM_ADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          extsel  = 2'b01;
        end
        MEM_RD: begin
          memRead = 1'b1;
          IorD    = 1'b1;
        end
        MEM_WB: begin
          regWrite  = 1'b1;
          writeData = 2'b01;
        end
        MEM_WR: begin
          memWrite = 1'b1;
          IorD     = 1'b1;
        end
        EXE_R: begin
          ALUSrcA  = 1'b1;
          ALUsel   = (funct == F_ADDU) ? 2'b00 : 2'b01;
          slt_ctrl = is_slt;
        end
        R_WB: begin
          regWrite  = 1'b1;
          regDst    = 2'b01;
          writeData = is_slt ? 2'b11 : 2'b00;
          slt_ctrl  = is_slt;
        end
        EXE_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          case (opcode)
            OP_ORI: begin
              extsel = 2'b00;
              ALUsel = 2'b10;
            end
            OP_LUI:  extsel = 2'b10;
            default: extsel = 2'b01;
          endcase
        end
        I_WB:    regWrite = !ovf_q;
        BRANCH: begin
          ALUSrcA = 1'b1;
          ALUsel  = 2'b01;
          if (opcode == OP_BGE) begin
            PCWr   = ge;
            nPCsel = 3'b101;
          end else begin
            PCWr   = zero;
            nPCsel = 3'b001;
          end
        end
        JUMP: begin
          PCWr   = 1'b1;
          nPCsel = 3'b011;
        end
        JAL: begin
          PCWr      = 1'b1;
          nPCsel    = 3'b010;
          regWrite  = 1'b1;
          regDst    = 2'b10;
          writeData = 2'b10;
        end
        JR: begin
          PCWr   = 1'b1;
          nPCsel = 3'b100;
        end
        HALT:    halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each driven cycle queues its expected control word,
// which the negedge monitor pops and compares against the DUT outputs.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] state;
    logic       halted, PCWr, IRWr, memRead, memWrite, IorD, regWrite;
    logic [1:0] regDst, writeData;
    logic [2:0] nPCsel;
    logic [1:0] extsel, ALUsel;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       slt_ctrl;
  } ctl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, ge = 1'b0, ovf = 1'b0, mem_ready = 1'b0;
  logic PCWr, IRWr, memRead, memWrite, IorD, regWrite, ALUSrcA, slt_ctrl, halted;
  logic [1:0] regDst, writeData, extsel, ALUsel, ALUSrcB;
  logic [2:0] nPCsel;
  logic [3:0] state;
  ctl_t obs;

  int n_checks = 0;
  int n_errors = 0;
  ctl_t  sb[$];
  string tq[$];

  multicycle_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .ge(ge),
    .ovf(ovf), .mem_ready(mem_ready), .PCWr(PCWr), .IRWr(IRWr), .memRead(memRead),
    .memWrite(memWrite), .IorD(IorD), .regWrite(regWrite), .regDst(regDst),
    .writeData(writeData), .nPCsel(nPCsel), .extsel(extsel), .ALUsel(ALUsel),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .slt_ctrl(slt_ctrl), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  always_comb obs = {state, halted, PCWr, IRWr, memRead, memWrite, IorD, regWrite, regDst,
                     writeData, nPCsel, extsel, ALUsel, ALUSrcA, ALUSrcB, slt_ctrl};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      ctl_t  e;
      string t;
      e = sb.pop_front();
      t = tq.pop_front();
      check_eq(t, 32'(obs), 32'(e));
    end
  end

  // Expected control words, one per state, written from the state table.
  function automatic ctl_t st(input logic [3:0] s);
    ctl_t c = '0;
    c.state = s;
    return c;
  endfunction
  function automatic ctl_t e_fetch(input logic rdy);
    ctl_t c = st(4'd0);
    c.memRead = 1'b1; c.ALUSrcB = 2'b01; c.IRWr = rdy; c.PCWr = rdy;
    return c;
  endfunction
  function automatic ctl_t e_decode();
    ctl_t c = st(4'd1);
    c.ALUSrcB = 2'b11; c.extsel = 2'b01;
    return c;
  endfunction
  function automatic ctl_t e_madr();
    ctl_t c = st(4'd2);
    c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b10; c.extsel = 2'b01;
    return c;
  endfunction
  function automatic ctl_t e_mrd();
    ctl_t c = st(4'd3);
    c.memRead = 1'b1; c.IorD = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_mwb();
    ctl_t c = st(4'd4);
    c.regWrite = 1'b1; c.writeData = 2'b01;
    return c;
  endfunction
  function automatic ctl_t e_mwr();
    ctl_t c = st(4'd5);
    c.memWrite = 1'b1; c.IorD = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_exer(input logic [1:0] alu, input logic slt);
    ctl_t c = st(4'd6);
    c.ALUSrcA = 1'b1; c.ALUsel = alu; c.slt_ctrl = slt;
    return c;
  endfunction
  function automatic ctl_t e_rwb(input logic slt);
    ctl_t c = st(4'd7);
    c.regWrite = 1'b1; c.regDst = 2'b01; c.writeData = slt ? 2'b11 : 2'b00; c.slt_ctrl = slt;
    return c;
  endfunction
  function automatic ctl_t e_exei(input logic [1:0] ext, input logic [1:0] alu);
    ctl_t c = st(4'd8);
    c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b10; c.extsel = ext; c.ALUsel = alu;
    return c;
  endfunction
  function automatic ctl_t e_iwb(input logic wr);
    ctl_t c = st(4'd9);
    c.regWrite = wr;
    return c;
  endfunction
  function automatic ctl_t e_branch(input logic pcwr, input logic [2:0] sel);
    ctl_t c = st(4'd10);
    c.ALUSrcA = 1'b1; c.ALUsel = 2'b01; c.PCWr = pcwr; c.nPCsel = sel;
    return c;
  endfunction
  function automatic ctl_t e_jump(input logic [3:0] s, input logic [2:0] sel);
    ctl_t c = st(s);
    c.PCWr = 1'b1; c.nPCsel = sel;
    return c;
  endfunction
  function automatic ctl_t e_jal();
    ctl_t c = e_jump(4'd12, 3'b010);
    c.regWrite = 1'b1; c.regDst = 2'b10; c.writeData = 2'b10;
    return c;
  endfunction
  function automatic ctl_t e_halt();
    ctl_t c = st(4'd15);
    c.halted = 1'b1;
    return c;
  endfunction

  task automatic cyc(input string tag, input logic rdy, input ctl_t e);
    mem_ready = rdy;
    sb.push_back(e);
    tq.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("reset", 32'(obs), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // addu, memory always ready
    set_instr(6'b000000, 6'b100001);
    cyc("addu_fetch", 1'b1, e_fetch(1'b1));
    cyc("addu_decode", 1'b1, e_decode());
    cyc("addu_exe", 1'b1, e_exer(2'b00, 1'b0));
    cyc("addu_wb", 1'b1, e_rwb(1'b0));

    // slt
    set_instr(6'b000000, 6'b101010);
    cyc("slt_fetch", 1'b1, e_fetch(1'b1));
    cyc("slt_decode", 1'b1, e_decode());
    cyc("slt_exe", 1'b1, e_exer(2'b01, 1'b1));
    cyc("slt_wb", 1'b1, e_rwb(1'b1));

    // lw with three wait cycles in MEM_RD
    set_instr(6'b100011, 6'b000000);
    cyc("lw_fetch", 1'b1, e_fetch(1'b1));
    cyc("lw_decode", 1'b1, e_decode());
    cyc("lw_madr", 1'b1, e_madr());
    for (int i = 0; i < 3; i++) cyc("lw_rd_wait", 1'b0, e_mrd());
    cyc("lw_rd", 1'b1, e_mrd());
    cyc("lw_wb", 1'b1, e_mwb());

    // sw with one wait cycle
    set_instr(6'b101011, 6'b000000);
    cyc("sw_fetch", 1'b1, e_fetch(1'b1));
    cyc("sw_decode", 1'b1, e_decode());
    cyc("sw_madr", 1'b1, e_madr());
    cyc("sw_wr_wait", 1'b0, e_mwr());
    cyc("sw_wr", 1'b1, e_mwr());

    // addi with and without overflow, then ori and lui
    set_instr(6'b001000, 6'b000000);
    ovf = 1'b1;
    cyc("addi_ov_fetch", 1'b1, e_fetch(1'b1));
    cyc("addi_ov_decode", 1'b1, e_decode());
    cyc("addi_ov_exe", 1'b1, e_exei(2'b01, 2'b00));
    ovf = 1'b0;
    cyc("addi_ov_wb", 1'b1, e_iwb(1'b0));
    cyc("addi_fetch", 1'b1, e_fetch(1'b1));
    cyc("addi_decode", 1'b1, e_decode());
    cyc("addi_exe", 1'b1, e_exei(2'b01, 2'b00));
    cyc("addi_wb", 1'b1, e_iwb(1'b1));
    set_instr(6'b001101, 6'b000000);
    ovf = 1'b1;
    cyc("ori_fetch", 1'b1, e_fetch(1'b1));
    cyc("ori_decode", 1'b1, e_decode());
    cyc("ori_exe", 1'b1, e_exei(2'b00, 2'b10));
    cyc("ori_wb", 1'b1, e_iwb(1'b1));
    ovf = 1'b0;
    set_instr(6'b001111, 6'b000000);
    cyc("lui_fetch", 1'b1, e_fetch(1'b1));
    cyc("lui_decode", 1'b1, e_decode());
    cyc("lui_exe", 1'b1, e_exei(2'b10, 2'b00));
    cyc("lui_wb", 1'b1, e_iwb(1'b1));

    // branches and jumps
    set_instr(6'b000100, 6'b000000);
    zero = 1'b0;
    ge = 1'b1;
    cyc("beq_fetch", 1'b1, e_fetch(1'b1));
    cyc("beq_decode", 1'b1, e_decode());
    cyc("beq_nt", 1'b1, e_branch(1'b0, 3'b001));
    set_instr(6'b000001, 6'b000000);
    zero = 1'b1;
    cyc("bge_fetch", 1'b1, e_fetch(1'b1));
    cyc("bge_decode", 1'b1, e_decode());
    cyc("bge_t", 1'b1, e_branch(1'b1, 3'b101));
    ge = 1'b0;
    set_instr(6'b000011, 6'b000000);
    cyc("jal_fetch", 1'b1, e_fetch(1'b1));
    cyc("jal_decode", 1'b1, e_decode());
    cyc("jal", 1'b1, e_jal());
    set_instr(6'b000010, 6'b000000);
    cyc("j_fetch", 1'b1, e_fetch(1'b1));
    cyc("j_decode", 1'b1, e_decode());
    cyc("j", 1'b1, e_jump(4'd11, 3'b011));
    set_instr(6'b000000, 6'b001000);
    cyc("jr_fetch", 1'b1, e_fetch(1'b1));
    cyc("jr_decode", 1'b1, e_decode());
    cyc("jr", 1'b1, e_jump(4'd13, 3'b100));

    // mem_ready on the last allowed wait cycle still proceeds
    set_instr(6'b000000, 6'b100001);
    for (int i = 0; i < 15; i++) cyc("edge_wait", 1'b0, e_fetch(1'b0));
    cyc("edge_fetch", 1'b1, e_fetch(1'b1));
    cyc("edge_decode", 1'b1, e_decode());
    cyc("edge_exe", 1'b1, e_exer(2'b00, 1'b0));
    cyc("edge_wb", 1'b1, e_rwb(1'b0));

    // fetch timeout into HALT, which absorbs even with mem_ready
    for (int i = 0; i < 16; i++) cyc("to_wait", 1'b0, e_fetch(1'b0));
    cyc("to_halt", 1'b1, e_halt());
    cyc("to_halt_hold", 1'b1, e_halt());
    do_reset();

    // illegal opcode and unknown funct
    set_instr(6'b111111, 6'b000000);
    cyc("ill_fetch", 1'b1, e_fetch(1'b1));
    cyc("ill_decode", 1'b1, e_decode());
    cyc("ill_halt", 1'b1, e_halt());
    do_reset();
    set_instr(6'b000000, 6'b111111);
    cyc("badfn_fetch", 1'b1, e_fetch(1'b1));
    cyc("badfn_decode", 1'b1, e_decode());
    cyc("badfn_halt", 1'b1, e_halt());
    do_reset();

    // asynchronous reset while memWrite is asserted
    set_instr(6'b101011, 6'b000000);
    cyc("ar_fetch", 1'b1, e_fetch(1'b1));
    cyc("ar_decode", 1'b1, e_decode());
    cyc("ar_madr", 1'b1, e_madr());
    cyc("ar_wr_wait", 1'b0, e_mwr());
    #2;
    check_eq("ar_memwrite_before", 32'(memWrite), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("ar_async", 32'(obs), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_instr(6'b000000, 6'b100001);
    cyc("ar_after_fetch", 1'b1, e_fetch(1'b1));
    cyc("ar_after_decode", 1'b1, e_decode());

    @(posedge clk);
    #1;
    if (sb.size() != 0) check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
